// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan receiver.
package seg7_pkg;

   localparam int unsigned SEG_W = 7;

   // Segment patterns, bit0 = a .. bit6 = g
   localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
   localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
   localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
   localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
   localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
   localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
   localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
   localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
   localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
   localparam logic [SEG_W-1:0] GLYPH_9 = 7'h67;
   localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
   localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
   localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
   localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
   localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
   localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Anything that is not one of the sixteen glyphs decodes to 0 with the error flag set.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] i_pattern,
   output logic [3:0]       o_value,
   output logic             o_err
);

   always_comb begin
      o_value = 4'h0;
      o_err   = 1'b0;
      case (i_pattern)
         GLYPH_0: o_value = 4'h0;
         GLYPH_1: o_value = 4'h1;
         GLYPH_2: o_value = 4'h2;
         GLYPH_3: o_value = 4'h3;
         GLYPH_4: o_value = 4'h4;
         GLYPH_5: o_value = 4'h5;
         GLYPH_6: o_value = 4'h6;
         GLYPH_7: o_value = 4'h7;
         GLYPH_8: o_value = 4'h8;
         GLYPH_9: o_value = 4'h9;
         GLYPH_A: o_value = 4'hA;
         GLYPH_B: o_value = 4'hB;
         GLYPH_C: o_value = 4'hC;
         GLYPH_D: o_value = 4'hD;
         GLYPH_E: o_value = 4'hE;
         GLYPH_F: o_value = 4'hF;
         default: o_err   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed seven-segment bus: waits for each strobed digit
// to settle, decodes it, and publishes a complete frame once every digit is seen.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned N_DIGITS       = 4,
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEG_W-1:0]      seg_i,
   input  logic                  dp_i,
   input  logic [N_DIGITS-1:0]   digit_i,
   output logic [4*N_DIGITS-1:0] value_o,
   output logic [N_DIGITS-1:0]   dp_o,
   output logic [N_DIGITS-1:0]   err_o,
   output logic                  frame_valid_o,
   output logic                  frame_err_o
);

   logic [SEG_W-1:0]      r_seg_s1, r_seg_s2, r_ref_seg, w_ref_seg_next, w_seg;
   logic                  r_dp_s1, r_dp_s2, r_ref_dp, w_ref_dp_next, w_dp;
   logic [N_DIGITS-1:0]   r_dig_s1, r_dig_s2, r_ref_dig, w_ref_dig_next, w_dig;
   logic [7:0]            r_cnt, w_cnt_next;
   logic [8:0]            w_cnt_inc;
   state_e                r_state, w_state_next;
   logic                  w_valid, w_match, w_capture, w_frame_done;
   logic [3:0]            w_dec_val;
   logic                  w_dec_err;
   logic [N_DIGITS-1:0]   r_mask, w_mask_next;
   logic [4*N_DIGITS-1:0] r_sh_val, r_value;
   logic [N_DIGITS-1:0]   r_sh_dp, r_sh_err, r_dp, r_err;
   logic                  r_frame_valid;

   // Polarity is normalised after the synchroniser so everything below is active-high
   assign w_seg = r_seg_s2 ^ {SEG_W{SEG_ACTIVE_LOW}};
   assign w_dp  = r_dp_s2 ^ SEG_ACTIVE_LOW;
   assign w_dig = r_dig_s2 ^ {N_DIGITS{SEG_ACTIVE_LOW}};

   assign w_valid      = (w_dig != '0) && ((w_dig & (w_dig - N_DIGITS'(1))) == '0);
   assign w_match      = (w_dig == r_ref_dig) && (w_seg == r_ref_seg) && (w_dp == r_ref_dp);
   assign w_cnt_inc    = {1'b0, r_cnt} + 9'd1;
   assign w_frame_done = &r_mask;

   seg7_pattern_decode u_decode (
      .i_pattern (r_ref_seg),
      .o_value   (w_dec_val),
      .o_err     (w_dec_err)
   );

   always_comb begin
      w_state_next   = r_state;
      w_ref_dig_next = r_ref_dig;
      w_ref_seg_next = r_ref_seg;
      w_ref_dp_next  = r_ref_dp;
      w_cnt_next     = r_cnt;
      w_capture      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_ref_dig_next = w_dig;
               w_ref_seg_next = w_seg;
               w_ref_dp_next  = w_dp;
               w_cnt_next     = 8'd1;
               w_state_next   = SETTLE;
            end
         end
         SETTLE: begin
            if (w_match) begin
               w_cnt_next = w_cnt_inc[7:0];
               if (w_cnt_inc >= 9'(STABLE_CYCLES)) w_state_next = CAPTURE;
            end else begin
               w_ref_dig_next = w_dig;
               w_ref_seg_next = w_seg;
               w_ref_dp_next  = w_dp;
               w_cnt_next     = 8'd1;
               if (!w_valid) w_state_next = IDLE;
            end
         end
         CAPTURE: begin
            w_capture    = 1'b1;
            w_state_next = HOLD;
         end
         HOLD: begin
            if (w_dig != r_ref_dig) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // A capture in the completion cycle survives the clear and starts the next frame
   assign w_mask_next = (w_frame_done ? '0 : r_mask) | (w_capture ? r_ref_dig : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_s1      <= '0;
         r_seg_s2      <= '0;
         r_dp_s1       <= 1'b0;
         r_dp_s2       <= 1'b0;
         r_dig_s1      <= '0;
         r_dig_s2      <= '0;
         r_state       <= IDLE;
         r_ref_dig     <= '0;
         r_ref_seg     <= '0;
         r_ref_dp      <= 1'b0;
         r_cnt         <= '0;
         r_mask        <= '0;
         r_sh_val      <= '0;
         r_sh_dp       <= '0;
         r_sh_err      <= '0;
         r_value       <= '0;
         r_dp          <= '0;
         r_err         <= '0;
         r_frame_valid <= 1'b0;
      end else begin
         r_seg_s1      <= seg_i;
         r_seg_s2      <= r_seg_s1;
         r_dp_s1       <= dp_i;
         r_dp_s2       <= r_dp_s1;
         r_dig_s1      <= digit_i;
         r_dig_s2      <= r_dig_s1;
         r_state       <= w_state_next;
         r_ref_dig     <= w_ref_dig_next;
         r_ref_seg     <= w_ref_seg_next;
         r_ref_dp      <= w_ref_dp_next;
         r_cnt         <= w_cnt_next;
         r_mask        <= w_mask_next;
         r_frame_valid <= w_frame_done;
         for (int k = 0; k < N_DIGITS; k++) begin
            if (w_capture && r_ref_dig[k]) begin
               r_sh_val[4*k +: 4] <= w_dec_val;
               r_sh_dp[k]         <= r_ref_dp;
               r_sh_err[k]        <= w_dec_err;
            end
         end
         if (w_frame_done) begin
            r_value <= r_sh_val;
            r_dp    <= r_sh_dp;
            r_err   <= r_sh_err;
         end
      end
   end

   assign value_o       = r_value;
   assign dp_o          = r_dp;
   assign err_o         = r_err;
   assign frame_valid_o = r_frame_valid;
   assign frame_err_o   = |r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus randomized frames checked against
// a glyph-table model; a second instance covers active-low buses with single-cycle settling.
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg, al_seg;
   logic        dp, al_dp;
   logic [3:0]  dig, al_dig;
   logic [15:0] value, al_value;
   logic [3:0]  dpo, erro, al_dpo, al_erro;
   logic        fv, ferr, al_fv, al_ferr;

   int n_vec = 0;
   int n_miss = 0;
   int pulses = 0;
   int al_pulses = 0;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [3:0] m_val [4];
   logic       m_dp  [4];
   logic       m_err [4];

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fv === 1'b1) pulses++;
      if (al_fv === 1'b1) al_pulses++;
   end

   seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .seg_i(seg), .dp_i(dp), .digit_i(dig),
      .value_o(value), .dp_o(dpo), .err_o(erro), .frame_valid_o(fv), .frame_err_o(ferr)
   );

   seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(1), .SEG_ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .seg_i(al_seg), .dp_i(al_dp), .digit_i(al_dig),
      .value_o(al_value), .dp_o(al_dpo), .err_o(al_erro), .frame_valid_o(al_fv),
      .frame_err_o(al_ferr)
   );

   function automatic logic [4:0] decode_ref(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (glyph[i] == p) return {1'b0, 4'(i)};
      return 5'b10000;
   endfunction

   // Expected {value, dp, err, frame_err} of the next published frame
   function automatic logic [24:0] model_frame();
      logic [15:0] v;
      logic [3:0]  d, e;
      for (int k = 0; k < 4; k++) begin
         v[4*k +: 4] = m_val[k];
         d[k]        = m_dp[k];
         e[k]        = m_err[k];
      end
      return {v, d, e, |e};
   endfunction

   task automatic drive_raw(input logic [3:0] d, input logic [6:0] s, input logic p,
                            input int cycles);
      dig = d;
      seg = s;
      dp  = p;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic scan(input int k, input logic [6:0] s, input logic p);
      drive_raw(4'(1 << k), s, p, 10);
      {m_err[k], m_val[k]} = decode_ref(s);
      m_dp[k] = p;
   endtask

   task automatic blank(input int cycles);
      drive_raw(4'b0000, 7'h00, 1'b0, cycles);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      dig    = '0;
      seg    = '0;
      dp     = 1'b0;
      al_dig = '1;
      al_seg = '1;
      al_dp  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         m_val[k] = '0;
         m_dp[k]  = 1'b0;
         m_err[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if ({value, dpo, erro, fv, ferr} !== 27'd0) begin
         n_miss++;
         $display("FAIL reset_outputs: got %h required 0", {value, dpo, erro, fv, ferr});
      end
      n_vec++;
      if ({al_value, al_dpo, al_erro, al_fv, al_ferr} !== 27'd0) begin
         n_miss++;
         $display("FAIL reset_outputs_al: got %h required 0",
                  {al_value, al_dpo, al_erro, al_fv, al_ferr});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_clean_scan();
      int p0 = pulses;
      scan(0, 7'h3F, 1'b0);
      scan(1, 7'h06, 1'b0);
      scan(2, 7'h5B, 1'b0);
      scan(3, 7'h4F, 1'b0);
      blank(10);
      n_vec++;
      if (pulses - p0 !== 1) begin
         n_miss++;
         $display("FAIL clean_pulses: got %0d required 1", pulses - p0);
      end
      n_vec++;
      if ({value, dpo, erro, ferr} !== {16'h3210, 4'b0, 4'b0, 1'b0}) begin
         n_miss++;
         $display("FAIL clean_frame: got %h required %h", {value, dpo, erro, ferr},
                  {16'h3210, 4'b0, 4'b0, 1'b0});
      end
   endtask

   task automatic test_glitch();
      int p0 = pulses;
      scan(0, 7'h6D, 1'b0);
      scan(1, 7'h66, 1'b1);
      drive_raw(4'b0100, 7'h7F, 1'b0, 2);
      drive_raw(4'b0100, 7'h67, 1'b0, 8);
      m_val[2] = 4'h9;
      m_dp[2]  = 1'b0;
      m_err[2] = 1'b0;
      scan(3, 7'h07, 1'b0);
      blank(10);
      n_vec++;
      if (pulses - p0 !== 1) begin
         n_miss++;
         $display("FAIL glitch_pulses: got %0d required 1", pulses - p0);
      end
      n_vec++;
      if ({value, dpo, erro, ferr} !== model_frame()) begin
         n_miss++;
         $display("FAIL glitch_frame: got %h required %h", {value, dpo, erro, ferr},
                  model_frame());
      end
   endtask

   task automatic test_illegal();
      int p0 = pulses;
      scan(0, 7'h77, 1'b0);
      scan(1, 7'h7C, 1'b0);
      scan(2, 7'h39, 1'b0);
      scan(3, 7'h49, 1'b1);
      blank(10);
      n_vec++;
      if (pulses - p0 !== 1) begin
         n_miss++;
         $display("FAIL illegal_pulses: got %0d required 1", pulses - p0);
      end
      n_vec++;
      if ({value[15:12], dpo, erro, ferr} !== {4'h0, 4'b1000, 4'b1000, 1'b1}) begin
         n_miss++;
         $display("FAIL illegal_glyph: got %h required %h", {value[15:12], dpo, erro, ferr},
                  {4'h0, 4'b1000, 4'b1000, 1'b1});
      end
      n_vec++;
      if ({value, dpo, erro, ferr} !== model_frame()) begin
         n_miss++;
         $display("FAIL illegal_frame: got %h required %h", {value, dpo, erro, ferr},
                  model_frame());
      end
   endtask

   task automatic test_multihot();
      int p0 = pulses;
      drive_raw(4'b0011, 7'h3F, 1'b0, 20);
      blank(5);
      n_vec++;
      if (pulses !== p0) begin
         n_miss++;
         $display("FAIL multihot_no_frame: got %0d pulses required 0", pulses - p0);
      end
      scan(0, 7'h77, 1'b0);
      scan(1, 7'h7C, 1'b0);
      scan(2, 7'h39, 1'b0);
      scan(3, 7'h5E, 1'b0);
      blank(10);
      n_vec++;
      if (pulses - p0 !== 1) begin
         n_miss++;
         $display("FAIL multihot_pulses: got %0d required 1", pulses - p0);
      end
      n_vec++;
      if ({value, erro, ferr} !== {16'hDCBA, 4'b0, 1'b0}) begin
         n_miss++;
         $display("FAIL multihot_frame: got %h required %h", {value, erro, ferr},
                  {16'hDCBA, 4'b0, 1'b0});
      end
   endtask

   task automatic test_reset_mid_frame();
      int p0;
      scan(0, glyph[$urandom_range(0, 15)], 1'b1);
      scan(1, glyph[$urandom_range(0, 15)], 1'b1);
      blank(1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({value, dpo, erro, fv, ferr} !== 27'd0) begin
         n_miss++;
         $display("FAIL reset_mid_frame: got %h required 0", {value, dpo, erro, fv, ferr});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      p0 = pulses;
      scan(2, glyph[$urandom_range(0, 15)], 1'b0);
      scan(3, glyph[$urandom_range(0, 15)], 1'b1);
      blank(10);
      n_vec++;
      if (pulses !== p0) begin
         n_miss++;
         $display("FAIL reset_mask_cleared: got %0d pulses required 0", pulses - p0);
      end
      scan(0, glyph[$urandom_range(0, 15)], 1'b0);
      scan(1, glyph[$urandom_range(0, 15)], 1'b0);
      blank(10);
      n_vec++;
      if (pulses - p0 !== 1) begin
         n_miss++;
         $display("FAIL reset_rescan_pulses: got %0d required 1", pulses - p0);
      end
      n_vec++;
      if ({value, dpo, erro, ferr} !== model_frame()) begin
         n_miss++;
         $display("FAIL reset_rescan_frame: got %h required %h", {value, dpo, erro, ferr},
                  model_frame());
      end
   endtask

   task automatic test_random();
      int order [4];
      for (int f = 0; f < 8; f++) begin
         int p0 = pulses;
         for (int i = 0; i < 4; i++) order[i] = i;
         for (int i = 3; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = order[i];
            order[i] = order[j];
            order[j] = t;
         end
         for (int i = 0; i < 4; i++) begin
            int gap = $urandom_range(0, 3);
            logic [6:0] pat = ($urandom_range(0, 5) == 0) ? 7'($urandom)
                                                          : glyph[$urandom_range(0, 15)];
            // Revisit an already captured digit so the latest value must win
            if (i == 3 && $urandom_range(0, 1) == 1) begin
               scan(order[0], glyph[$urandom_range(0, 15)], 1'($urandom));
               blank(1);
            end
            scan(order[i], pat, 1'($urandom));
            if (gap != 0) blank(gap);
         end
         blank(10);
         n_vec++;
         if (pulses - p0 !== 1) begin
            n_miss++;
            $display("FAIL random_pulses[%0d]: got %0d required 1", f, pulses - p0);
         end
         n_vec++;
         if ({value, dpo, erro, ferr} !== model_frame()) begin
            n_miss++;
            $display("FAIL random_frame[%0d]: got %h required %h", f,
                     {value, dpo, erro, ferr}, model_frame());
         end
      end
   endtask

   task automatic test_active_low();
      logic [6:0] pats [4] = '{7'h71, 7'h79, 7'h5E, 7'h7D};
      n_vec++;
      if (al_pulses !== 0) begin
         n_miss++;
         $display("FAIL al_idle_no_frame: got %0d pulses required 0", al_pulses);
      end
      for (int k = 0; k < 4; k++) begin
         al_dig = ~4'(1 << k);
         al_seg = ~pats[k];
         al_dp  = 1'b1;
         repeat (10) @(posedge clk);
         #1;
      end
      al_dig = '1;
      al_seg = '1;
      repeat (10) @(posedge clk);
      #1;
      n_vec++;
      if (al_pulses !== 1) begin
         n_miss++;
         $display("FAIL al_pulses: got %0d required 1", al_pulses);
      end
      n_vec++;
      if ({al_value, al_dpo, al_erro, al_ferr} !== {16'h6DEF, 4'b0, 4'b0, 1'b0}) begin
         n_miss++;
         $display("FAIL al_frame: got %h required %h", {al_value, al_dpo, al_erro, al_ferr},
                  {16'h6DEF, 4'b0, 4'b0, 1'b0});
      end
   endtask

   initial begin
      test_reset();
      test_clean_scan();
      test_glitch();
      test_illegal();
      test_multihot();
      test_reset_mid_frame();
      test_random();
      test_active_low();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
